// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field, HALT opcode and fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t HALT_OPCODE = 6'h3F;

  localparam logic [1:0] FETCH_ENC  = 2'd0;
  localparam logic [1:0] HOLD_ENC   = 2'd1;
  localparam logic [1:0] HALTED_ENC = 2'd2;

  typedef enum logic [1:0] {
    FETCH  = FETCH_ENC,
    HOLD   = HOLD_ENC,
    HALTED = HALTED_ENC
  } fetch_state_t;

  function automatic opcode_t opcode_of(input word_t w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_unit_ifid_latch.sv
// IF/ID pipeline register: clear drops valid only, enable loads a real instruction.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  input  logic  clr,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;

  // Next-state selection; clear wins over enable.
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = instr_i;
      npc_d   = npc_i;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register update with asynchronous reset.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      instr_q <= 32'd0;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch/hold/halt FSM with a one-entry skid buffer
// feeding the IF/ID register.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter opcode_t HALT_OP = HALT_OPCODE
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t imemaddr,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  flush,
  output logic  imemREN,
  output word_t iaddr,
  output logic  pcEN,
  output word_t ifid_instr,
  output word_t ifid_npc,
  output logic  ifid_valid
);

  fetch_state_t state_q, state_d;
  word_t        skid_instr_q, skid_instr_d;
  word_t        skid_npc_q, skid_npc_d;
  logic         latch_en, latch_clr;
  word_t        latch_instr, latch_npc;
  word_t        fetch_npc;

  assign fetch_npc = imemaddr + 32'd4;
  assign iaddr     = imemaddr;
  assign imemREN   = (state_q == FETCH);
  assign pcEN      = ((state_q == FETCH) && ihit) || flush;

  // FSM, skid buffer and IF/ID control; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    skid_instr_d = skid_instr_q;
    skid_npc_d   = skid_npc_q;
    latch_en     = 1'b0;
    latch_clr    = 1'b0;
    latch_instr  = imemload;
    latch_npc    = fetch_npc;
    if (flush) begin
      latch_clr    = 1'b1;
      state_d      = FETCH;
      skid_instr_d = 32'd0;
      skid_npc_d   = 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit && stall) begin
            skid_instr_d = imemload;
            skid_npc_d   = fetch_npc;
            state_d      = HOLD;
          end else if (ihit) begin
            latch_en = 1'b1;
            state_d  = (opcode_of(imemload) == HALT_OP) ? HALTED : FETCH;
          end else if (!stall) begin
            latch_clr = 1'b1;
          end else begin
            latch_clr = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            latch_en    = 1'b1;
            latch_instr = skid_instr_q;
            latch_npc   = skid_npc_q;
            state_d     = (opcode_of(skid_instr_q) == HALT_OP) ? HALTED : FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        HALTED: begin
          if (!stall) begin
            latch_clr = 1'b1;
          end else begin
            latch_clr = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and skid buffer registers.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      skid_instr_q <= 32'd0;
      skid_npc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
    end
  end

  ifid_latch u_ifid (
    .CLK     (CLK),
    .nRST    (nRST),
    .en      (latch_en),
    .clr     (latch_clr),
    .instr_i (latch_instr),
    .npc_i   (latch_npc),
    .instr_o (ifid_instr),
    .npc_o   (ifid_npc),
    .valid_o (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic
// against a queue-based model of the fetch stage.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  word_t imemaddr, imemload;
  logic  ihit, stall, flush;
  logic  imemREN, pcEN, ifid_valid;
  word_t iaddr, ifid_instr, ifid_npc;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: IF/ID contents, pending skid entries and a halted flag.
  word_t       m_instr, m_npc;
  logic        m_valid, m_halted;
  logic [63:0] m_skid[$];

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .stall(stall), .flush(flush), .imemREN(imemREN),
    .iaddr(iaddr), .pcEN(pcEN), .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc), .ifid_valid(ifid_valid)
  );

  always #5 CLK = ~CLK;

  function automatic logic m_fetching();
    return !m_halted && (m_skid.size() == 0);
  endfunction

  function automatic logic is_halt(input word_t w);
    return w[31:26] == 6'h3F;
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
    m_skid.delete();
  endtask

  task automatic m_clock();
    logic [63:0] e;
    if (flush) begin
      m_valid = 1'b0; m_halted = 1'b0; m_skid.delete();
    end else if (m_skid.size() > 0) begin
      if (!stall) begin
        e = m_skid.pop_front();
        m_instr = e[63:32]; m_npc = e[31:0]; m_valid = 1'b1;
        if (is_halt(m_instr)) m_halted = 1'b1;
      end
    end else if (m_halted) begin
      if (!stall) m_valid = 1'b0;
    end else if (ihit) begin
      if (stall) m_skid.push_back({imemload, imemaddr + 32'd4});
      else begin
        m_instr = imemload; m_npc = imemaddr + 32'd4; m_valid = 1'b1;
        if (is_halt(imemload)) m_halted = 1'b1;
      end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic ih, input logic st, input logic fl,
                       input word_t addr, input word_t load);
    ihit = ih; stall = st; flush = fl; imemaddr = addr; imemload = load;
  endtask

  // Check combinational outputs, clock once, then check the IF/ID register.
  task automatic cycle(input string tag);
    #1;
    chk({tag, "/imemREN"}, imemREN, m_fetching());
    chk({tag, "/pcEN"}, pcEN, (m_fetching() && ihit) || flush);
    chk({tag, "/iaddr"}, iaddr, imemaddr);
    @(posedge CLK);
    m_clock();
    #1;
    chk({tag, "/valid"}, ifid_valid, m_valid);
    chk({tag, "/instr"}, ifid_instr, m_instr);
    chk({tag, "/npc"}, ifid_npc, m_npc);
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h20010005);
    m_reset();
    #2;
    chk("rst/valid", ifid_valid, 32'd0);
    chk("rst/instr", ifid_instr, 32'd0);
    chk("rst/npc", ifid_npc, 32'd0);
    chk("rst/imemREN", imemREN, 32'd1);
    chk("rst/pcEN", pcEN, 32'd1);
    chk("rst/iaddr", iaddr, 32'd0);
    #10 nRST = 1'b1;

    cycle("first");
    chk("first/instr_lit", ifid_instr, 32'h20010005);
    chk("first/npc_lit", ifid_npc, 32'h4);

    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h8C220000);
    cycle("skid_in");
    chk("skid_in/held", ifid_instr, 32'h20010005);
    drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    cycle("hold_stall");
    drive(1'b1, 1'b0, 1'b0, 32'h14, 32'h12345678);
    cycle("skid_out");
    chk("skid_out/instr_lit", ifid_instr, 32'h8C220000);
    chk("skid_out/npc_lit", ifid_npc, 32'h14);

    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h01234567);
    cycle("flush");
    chk("flush/valid_lit", ifid_valid, 32'd0);
    chk("flush/ren_after", imemREN, 32'd1);

    drive(1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000020);
    cycle("wrap");
    chk("wrap/npc_lit", ifid_npc, 32'h0);

    drive(1'b1, 1'b0, 1'b0, 32'h24, 32'hFC000000);
    cycle("halt_in");
    drive(1'b1, 1'b0, 1'b0, 32'h28, 32'h11111111);
    #1;
    chk("halted/ren_lit", imemREN, 32'd0);
    chk("halted/pcen_lit", pcEN, 32'd0);
    cycle("halted");
    drive(1'b1, 1'b0, 1'b1, 32'h28, 32'h11111111);
    #1;
    chk("unhalt/pcen_lit", pcEN, 32'd1);
    cycle("unhalt");
    chk("unhalt/ren_lit", imemREN, 32'd1);

    drive(1'b1, 1'b1, 1'b0, 32'h30, 32'hAAAA0001);
    cycle("pre_rst_hold");
    drive(1'b0, 1'b0, 1'b0, 32'h34, 32'h0);
    #3 nRST = 1'b0;
    m_reset();
    #1;
    chk("midrst/valid", ifid_valid, 32'd0);
    chk("midrst/imemREN", imemREN, 32'd1);
    chk("midrst/pcEN", pcEN, 32'd0);
    #2 nRST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 400; i++) begin
      logic  ih, st, fl;
      word_t addr, load;
      ih   = ($urandom_range(0, 9) < 7);
      st   = ($urandom_range(0, 9) < 3);
      fl   = ($urandom_range(0, 19) == 0);
      addr = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      load = $urandom;
      if (!st && $urandom_range(0, 9) == 0) load[31:26] = 6'h3F;
      else if (load[31:26] == 6'h3F) load[31:26] = 6'h3E;
      drive(ih, st, fl, addr, load);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
